// File: rtl/block_feeder.sv
// rtl/block_feeder.sv - packs a word stream into 8x8 blocks and sequences the engine start handshake
// Define BLOCK_FEEDER_PINGPONG_EN for two ping-pong banks; otherwise a single bank is used.
module block_feeder #(
    parameter int DATA_W      = 32,
    parameter int BLOCK_WORDS = 64,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    input  logic [7:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic [3:0]        eng_state,
    output logic              start,
    output logic [CNT_W-1:0]  blocks_done,
    output logic              err_last
);
    localparam int              IDX_W    = $clog2(BLOCK_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_WORDS - 1);
    localparam logic [7:0]      ADDR_LIM = 8'(BLOCK_WORDS);
    localparam logic [3:0]      ENG_IDLE    = 4'd0;
    localparam logic [3:0]      ENG_PROCESS = 4'd2;
    localparam logic [3:0]      ENG_DONE    = 4'd4;
`ifdef BLOCK_FEEDER_PINGPONG_EN
    localparam logic PINGPONG = 1'b1;
`else
    localparam logic PINGPONG = 1'b0;
`endif

    typedef enum logic [1:0] {F_IDLE, F_ARM, F_RUN, F_DROP} fstate_t;

    fstate_t                  state, next_state;
    logic [DATA_W-1:0]        mem [0:1][0:BLOCK_WORDS-1];
    logic [BLOCK_WORDS-1:0]   bitmap [0:1];
    logic [1:0]               full, full_n;
    logic                     wr_sel, wr_sel_n, rd_sel, rd_sel_n;
    logic [IDX_W-1:0]         wr_idx;
    logic                     xfer, close, release_bank, start_d, count_en;

    assign xfer         = s_valid && s_ready;
    assign close        = xfer && (s_last || wr_idx == LAST_IDX);
    assign release_bank = (state == F_ARM) && (eng_state == ENG_PROCESS);

    // Release always targets rd_sel and a close always targets the non-full fill bank, so they never collide.
    always_comb begin
        full_n = full;
        if (release_bank) full_n[rd_sel] = 1'b0;
        if (close)        full_n[wr_sel] = 1'b1;
        wr_sel_n = wr_sel ^ (close & PINGPONG);
        rd_sel_n = rd_sel ^ (release_bank & PINGPONG);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full      <= '0;
            wr_sel    <= 1'b0;
            rd_sel    <= 1'b0;
            wr_idx    <= '0;
            s_ready   <= 1'b1;
            err_last  <= 1'b0;
            bitmap[0] <= '0;
            bitmap[1] <= '0;
        end else begin
            full    <= full_n;
            wr_sel  <= wr_sel_n;
            rd_sel  <= rd_sel_n;
            s_ready <= !full_n[wr_sel_n];
            if (release_bank) bitmap[rd_sel] <= '0;
            if (xfer) begin
                bitmap[wr_sel][wr_idx] <= 1'b1;
                wr_idx <= close ? '0 : wr_idx + 1'b1;
                if (s_last != (wr_idx == LAST_IDX)) err_last <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (xfer) mem[wr_sel][wr_idx] <= s_data;
    end

    // Unwritten words read as zero so a short block is zero-padded to 64 words.
    always_comb begin
        rd_data = '0;
        if (rd_addr < ADDR_LIM && bitmap[rd_sel][rd_addr[IDX_W-1:0]])
            rd_data = mem[rd_sel][rd_addr[IDX_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= F_IDLE;
            start       <= 1'b0;
            blocks_done <= '0;
        end else begin
            state       <= next_state;
            start       <= start_d;
            blocks_done <= blocks_done + CNT_W'(count_en);
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            F_IDLE:  if (full[rd_sel] && eng_state == ENG_IDLE) next_state = F_ARM;
            F_ARM:   if (eng_state == ENG_PROCESS)              next_state = F_RUN;
            F_RUN:   if (eng_state == ENG_DONE)                 next_state = F_DROP;
            F_DROP:  if (eng_state == ENG_IDLE)                 next_state = F_IDLE;
            default: next_state = F_IDLE;
        endcase
    end

    // start falls on the same edge that observes DONE, guaranteeing a low period before re-arming.
    always_comb begin
        start_d  = (state == F_ARM) || (state == F_RUN && eng_state != ENG_DONE);
        count_en = (state == F_RUN) && (eng_state == ENG_DONE);
    end
endmodule

// File: doc/block_feeder.md
# block_feeder

Upstream stage of `user_functional_module`. Accepts a valid/ready stream of 32-bit pixel/coefficient words and packs them into 64-word (8x8) blocks in ping-pong buffers. It serves the engine's address-driven load port, and sequences the engine's `start` level handshake by watching its `state_out`. Counts completed blocks and flags framing errors.

## Interface
- `DATA_W`, 32, word width.
- `BLOCK_WORDS`, 64, words per block; fixed by the engine.
- `CNT_W`, 16, width of `blocks_done`.
- `clk`  in  1  clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `s_valid`  in  1  input word valid.
- `s_ready`  out  1  feeder can accept a word.
- `s_data`  in  DATA_W  input word.
- `s_last`  in  1  marks the final word of a block.
- `rd_addr`  in  8  engine load address (engine `data_in_addr`).
- `rd_data`  out  DATA_W  word at `rd_addr` in the read bank (engine `data_in`).
- `eng_state`  in  4  engine `state_out`: 0 IDLE, 1 LOAD, 2 PROCESS, 3 SAVE, 4 DONE.
- `start`  out  1  engine start level.
- `blocks_done`  out  CNT_W  blocks completed by the engine; wraps.
- `err_last`  out  1  sticky framing error.

## Operation
- **Write side.**
  - Two banks of 64 words, each with a 64-bit written bitmap and a `full` flag.
  - `wr_sel` selects the fill bank; `wr_idx` (0..63) is the fill pointer.
  - `s_ready = !full[wr_sel]`.
  - A transfer (`s_valid && s_ready`) writes `s_data` to `wr_idx`, sets its bitmap bit, and increments `wr_idx`.
- **Block close.** The bank closes when a transfer has `s_last`=1 or `wr_idx`==63.
  - On close: `full`:=1, `wr_idx`:=0, `wr_sel` toggles.
- **Framing errors.** `err_last` sets on `s_last` with `wr_idx`!=63, or on `wr_idx`==63 without `s_last`. The bank still closes in both cases.
- **Read port.**
  - `rd_data` is combinational from bank `rd_sel`.
  - It returns 0 if `rd_addr`>=64 or the bitmap bit is clear, so short blocks are zero-padded.
- **Feeder FSM.**
  - F_IDLE: if `full[rd_sel]` and `eng_state`==0, go to F_ARM.
  - F_ARM: `start`=1; on `eng_state`==2, go to F_RUN and release the bank (`full`:=0, bitmap:=0, `rd_sel` toggles). The engine has then latched all 64 words.
  - F_RUN: `start`=1; on `eng_state`==4, increment `blocks_done` and go to F_DROP.
  - F_DROP: `start`=0; on `eng_state`==0, go to F_IDLE.
- **Unexpected engine state.** Any `eng_state` not listed for the current FSM state leaves the FSM in place.
- **Simultaneous release and fill.** Allowed. The released bank is always `rd_sel`, and while both banks are in use the fill bank is the other one. If both banks were full, `s_ready` rises the cycle after release.
- **Release of the last full bank.** If the write side was stalled because both banks were full, `wr_sel` already equals the released bank, so filling resumes there.

## Timing
- **Reset values:**
  - `s_ready`=1
  - `start`=0
  - `blocks_done`=0
  - `err_last`=0
  - `rd_data`=0 (bitmaps clear)
  - FSM F_IDLE, `wr_sel`=`rd_sel`=0, `wr_idx`=0, all `full`=0
- **Reset mid-operation.** Discards all buffered data. `start` drops the cycle after `rst_n` is sampled low.
- **Throughput.** One word per cycle while `s_ready`=1.
- **Close-to-start latency.** `full` is set at the edge that takes the 64th/last word. `start` rises 2 cycles after that edge when the engine is idle: F_IDLE detect, then F_ARM registered output.
- **Read latency.** `rd_data` follows `rd_addr` in the same cycle, which the engine needs because it samples `data_in` at the same edge it advances `data_in_addr`.
- **Hold rule.** `start` stays high from F_ARM until `eng_state`==4 is observed, then is low for at least 1 cycle before the next block. The engine needs this low period to re-detect a rising edge.
- **Register outputs.** `s_ready`, `start`, `blocks_done` and `err_last` are registered.

## Configuration
- **Macro `BLOCK_FEEDER_PINGPONG_EN`.**
- **Defined:** two banks, as above. The next block fills while the engine processes.
- **Undefined:**
  - Single bank; `wr_sel`/`rd_sel` fixed at 0.
  - `s_ready`=0 from close until release (F_ARM to F_RUN).
  - All other behaviour unchanged.

## Test plan
- **Basic block.** Reset, stream words 0..63 with `s_last` on word 63, model the engine → `start` rises 2 cycles after the last transfer; the engine reads `rd_data`==addr for addr 0..63; `blocks_done`=1; `err_last`=0.
- **Short block.** 10 words 0xA0..0xA9 with `s_last` on the 10th → `err_last`=1; `rd_data` at addr 10..63 reads 0; `start` is issued.
- **Back-to-back with backpressure.** Stream 3 blocks continuously with a slow engine (PROCESS 200 cycles) → `s_ready` drops only when both banks are full; data order is preserved; `blocks_done`=3.
- **Start handshake.** Hold `eng_state`=4 for 5 cycles after DONE → `start`=0 throughout; no new `start` until `eng_state`==0.
- **Single-bank build.** Build without `BLOCK_FEEDER_PINGPONG_EN` → `s_ready`=0 from close until `eng_state`==2; then the next block is accepted.
- **Reset mid-operation.** Assert reset while half a block is written and the engine is in LOAD → all outputs return to reset values next cycle; a fresh block then completes normally.
